// File: rtl/axis_axi_pkg.sv
// Shared types and helpers for the AXI slave to AXIS memory client port.
// The byte-count helper is also used on the crossbar side.
package axis_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WRESP,
    ST_RDATA
  } port_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // (len+1) << size never exceeds 17 bits, so 32 bits is always enough.
  function automatic logic [31:0] axi_bytes(
    input logic [7:0] len,
    input logic [2:0] size
  );
    logic [31:0] n;
    n = 32'(len) + 32'd1;
    return n << size;
  endfunction

endpackage

// File: rtl/axi_slave_to_axis_port.sv
// AXI4 slave front end for one AXIS-style memory client port.
// One transaction in flight; reads and writes alternate under contention.
module axi_slave_to_axis_port
  import axis_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  aclk,
  input  logic                  resetn,

  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,

  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,

  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,

  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,

  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,

  output logic                  m_avalid,
  output logic                  m_arnw,
  output logic [ADDR_WIDTH-1:0] m_aaddr,
  output logic [ADDR_WIDTH-1:0] m_abytes,
  input  logic                  m_aready,

  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic                  m_wlast,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,

  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic                  m_rlast,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [STRB_WIDTH-1:0] m_rstrb
);

  port_state_e           state_q, state_d;
  logic                  last_wr_q, last_wr_d;
  logic                  rnw_q, rnw_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] bytes_q, bytes_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;

  logic grant_wr;
  logic grant_rd;
  logic rd_last;

  // Bursts are always treated as INCR; the downstream stream marks its own end.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awburst, s_axi_arburst, m_rlast, m_rstrb};

  assign grant_wr = s_axi_awvalid && (!s_axi_arvalid || !last_wr_q);
  assign grant_rd = s_axi_arvalid && (!s_axi_awvalid || last_wr_q);
  assign rd_last  = (cnt_q == len_q);

  assign m_arnw      = rnw_q;
  assign m_aaddr     = addr_q;
  assign m_abytes    = bytes_q;
  assign s_axi_bid   = id_q;
  assign s_axi_bresp = AXI_RESP_OKAY;
  assign s_axi_rid   = id_q;
  assign s_axi_rresp = AXI_RESP_OKAY;

  always_comb begin
    state_d       = state_q;
    last_wr_d     = last_wr_q;
    rnw_d         = rnw_q;
    id_d          = id_q;
    addr_d        = addr_q;
    bytes_d       = bytes_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    s_axi_rdata   = '0;
    m_avalid      = 1'b0;
    m_wvalid      = 1'b0;
    m_wlast       = 1'b0;
    m_wdata       = '0;
    m_wstrb       = '0;
    m_rready      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_axi_awready = grant_wr;
        s_axi_arready = grant_rd;
        if (grant_wr) begin
          rnw_d     = 1'b1;
          last_wr_d = 1'b1;
          id_d      = s_axi_awid;
          addr_d    = s_axi_awaddr;
          len_d     = s_axi_awlen;
          bytes_d   = ADDR_WIDTH'(axi_bytes(s_axi_awlen, s_axi_awsize));
          state_d   = ST_ADDR;
        end else if (grant_rd) begin
          rnw_d     = 1'b0;
          last_wr_d = 1'b0;
          id_d      = s_axi_arid;
          addr_d    = s_axi_araddr;
          len_d     = s_axi_arlen;
          bytes_d   = ADDR_WIDTH'(axi_bytes(s_axi_arlen, s_axi_arsize));
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_avalid = 1'b1;
        if (m_aready) begin
          cnt_d   = '0;
          state_d = rnw_q ? ST_WDATA : ST_RDATA;
        end
      end
      ST_WDATA: begin
        m_wvalid     = s_axi_wvalid;
        s_axi_wready = m_wready;
        m_wdata      = s_axi_wdata;
        m_wstrb      = s_axi_wstrb;
        m_wlast      = s_axi_wlast;
        if (s_axi_wvalid && m_wready && s_axi_wlast) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          state_d = ST_IDLE;
        end
      end
      ST_RDATA: begin
        s_axi_rvalid = m_rvalid;
        m_rready     = s_axi_rready;
        s_axi_rdata  = m_rdata;
        s_axi_rlast  = rd_last;
        if (m_rvalid && s_axi_rready) begin
          cnt_d = cnt_q + 8'd1;
          if (rd_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b1;
      rnw_q     <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      bytes_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      rnw_q     <= rnw_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      bytes_q   <= bytes_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_to_axis_port.sv
// Randomized bench for axi_slave_to_axis_port.
// A transaction-level model predicts handshakes, data and responses.
module tb_axi_slave_to_axis_port;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = 4;
  localparam int IW  = 8;
  localparam int TMO = 3000;

  logic aclk = 1'b0;
  logic resetn = 1'b1;
  always #5 aclk = ~aclk;

  logic [IW-1:0] s_axi_awid = '0;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic [7:0]    s_axi_awlen = '0;
  logic [2:0]    s_axi_awsize = '0;
  logic [1:0]    s_axi_awburst = 2'b01;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [SW-1:0] s_axi_wstrb = '0;
  logic          s_axi_wlast = 1'b0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [IW-1:0] s_axi_bid;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic [IW-1:0] s_axi_arid = '0;
  logic [AW-1:0] s_axi_araddr = '0;
  logic [7:0]    s_axi_arlen = '0;
  logic [2:0]    s_axi_arsize = '0;
  logic [1:0]    s_axi_arburst = 2'b01;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [IW-1:0] s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;
  logic          m_avalid;
  logic          m_arnw;
  logic [AW-1:0] m_aaddr;
  logic [AW-1:0] m_abytes;
  logic          m_aready = 1'b1;
  logic          m_wvalid;
  logic          m_wready = 1'b1;
  logic          m_wlast;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_rvalid = 1'b1;
  logic          m_rready;
  logic          m_rlast = 1'b0;
  logic [DW-1:0] m_rdata;
  logic [SW-1:0] m_rstrb = 4'hF;

  axi_slave_to_axis_port dut (
    .aclk(aclk), .resetn(resetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_avalid(m_avalid), .m_arnw(m_arnw), .m_aaddr(m_aaddr),
    .m_abytes(m_abytes), .m_aready(m_aready),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .m_rdata(m_rdata), .m_rstrb(m_rstrb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake within %0d cycles, required one",
             nm, TMO);
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } wbeat_t;

  // transaction-level model
  wbeat_t        exp_w[$];
  bit            grant_log[$];
  bit            mon_en = 1'b0;
  bit            bp = 1'b0;
  bit            r_hs = 1'b0;
  logic [31:0]   rd_next = 32'h1000;
  bit            mdl_lw = 1'b1;
  int            mdl_stage = 0;
  bit            mdl_rnw = 1'b0;
  logic [IW-1:0] mdl_id = '0;
  logic [AW-1:0] mdl_addr = '0;
  logic [AW-1:0] mdl_bytes = '0;
  int            mdl_len = 0;
  int            mdl_beats = 0;
  logic [AW-1:0] seen_addr = '0;
  logic [AW-1:0] seen_bytes = '0;
  bit            seen_rnw = 1'b0;
  int            seen_wbeats = 0;
  int            seen_rbeats = 0;

  assign m_rdata = rd_next;

  task automatic monitor_cycle();
    bit exp_awr, exp_arr, w_on, r_on;
    wbeat_t b;
    exp_awr = 1'b0;
    exp_arr = 1'b0;
    if (mdl_stage == 0) begin
      exp_awr = s_axi_awvalid && (!s_axi_arvalid || !mdl_lw);
      exp_arr = s_axi_arvalid && (!s_axi_awvalid || mdl_lw);
    end
    w_on = (mdl_stage == 2) && mdl_rnw;
    r_on = (mdl_stage == 2) && !mdl_rnw;
    check("aw_ar_both", s_axi_awready && s_axi_arready, 0);
    check("awready", s_axi_awready, exp_awr);
    check("arready", s_axi_arready, exp_arr);
    check("m_avalid", m_avalid, mdl_stage == 1);
    check("m_wvalid", m_wvalid, w_on && s_axi_wvalid);
    check("s_wready", s_axi_wready, w_on && m_wready);
    check("bvalid", s_axi_bvalid, mdl_stage == 3);
    check("s_rvalid", s_axi_rvalid, r_on && m_rvalid);
    check("m_rready", m_rready, r_on && s_axi_rready);
    case (mdl_stage)
      0: begin
        if (exp_awr) begin
          mdl_rnw = 1'b1; mdl_id = s_axi_awid; mdl_addr = s_axi_awaddr;
          mdl_len = int'(s_axi_awlen);
          mdl_bytes = (32'(s_axi_awlen) + 32'd1) << s_axi_awsize;
          mdl_lw = 1'b1; mdl_stage = 1; grant_log.push_back(1'b1);
        end else if (exp_arr) begin
          mdl_rnw = 1'b0; mdl_id = s_axi_arid; mdl_addr = s_axi_araddr;
          mdl_len = int'(s_axi_arlen);
          mdl_bytes = (32'(s_axi_arlen) + 32'd1) << s_axi_arsize;
          mdl_lw = 1'b0; mdl_stage = 1; grant_log.push_back(1'b0);
        end
      end
      1: begin
        check("m_aaddr", m_aaddr, mdl_addr);
        check("m_abytes", m_abytes, mdl_bytes);
        check("m_arnw", m_arnw, mdl_rnw);
        if (m_aready) begin
          seen_addr = m_aaddr; seen_bytes = m_abytes; seen_rnw = m_arnw;
          mdl_stage = 2; mdl_beats = 0;
        end
      end
      2: begin
        if (mdl_rnw && s_axi_wvalid && m_wready) begin
          if (exp_w.size() == 0) begin
            check("w_extra_beat", 1, 0);
          end else begin
            b = exp_w.pop_front();
            check("m_wdata", m_wdata, b.data);
            check("m_wstrb", m_wstrb, b.strb);
            check("m_wlast", m_wlast, b.last);
          end
          mdl_beats++;
          if (s_axi_wlast) begin
            seen_wbeats = mdl_beats; mdl_stage = 3;
          end
        end else if (!mdl_rnw && m_rvalid && s_axi_rready) begin
          check("rdata", s_axi_rdata, rd_next);
          check("rid", s_axi_rid, mdl_id);
          check("rresp", s_axi_rresp, 0);
          check("rlast", s_axi_rlast, mdl_beats == mdl_len);
          r_hs = 1'b1;
          mdl_beats++;
          if (mdl_beats == mdl_len + 1) begin
            seen_rbeats = mdl_beats; mdl_stage = 0;
          end
        end
      end
      3: begin
        check("bid", s_axi_bid, mdl_id);
        check("bresp", s_axi_bresp, 0);
        if (s_axi_bready) mdl_stage = 0;
      end
      default: mdl_stage = 0;
    endcase
  endtask

  initial forever begin
    @(negedge aclk);
    if (mon_en) monitor_cycle();
  end

  // downstream memory side: readiness and a running read-data counter
  initial forever begin
    @(posedge aclk);
    #1;
    if (r_hs) rd_next = rd_next + 32'd1;
    r_hs = 1'b0;
    m_aready = bp ? 1'($urandom) : 1'b1;
    m_wready = bp ? 1'($urandom) : 1'b1;
    m_rvalid = bp ? 1'($urandom) : 1'b1;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] a,
                         input logic [7:0] len, input logic [2:0] sz);
    s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len;
    s_axi_awsize = sz; s_axi_awvalid = 1'b1;
    for (int t = 0; t < TMO; t++) begin
      @(negedge aclk);
      if (s_axi_awready) begin
        tick();
        s_axi_awvalid = 1'b0;
        return;
      end
    end
    s_axi_awvalid = 1'b0;
    tmo("aw_handshake");
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] a,
                         input logic [7:0] len, input logic [2:0] sz);
    s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len;
    s_axi_arsize = sz; s_axi_arvalid = 1'b1;
    for (int t = 0; t < TMO; t++) begin
      @(negedge aclk);
      if (s_axi_arready) begin
        tick();
        s_axi_arvalid = 1'b0;
        return;
      end
    end
    s_axi_arvalid = 1'b0;
    tmo("ar_handshake");
  endtask

  task automatic send_w(input int n, input bit incr, input int stop_after);
    wbeat_t b[$];
    wbeat_t x;
    bit ok;
    for (int i = 0; i < n; i++) begin
      x.data = incr ? 32'(i + 1) : $urandom;
      x.strb = incr ? 4'hF : 4'($urandom);
      x.last = (i == n - 1);
      b.push_back(x);
      exp_w.push_back(x);
    end
    for (int i = 0; i < n && i < stop_after; i++) begin
      if (bp) repeat ($urandom % 3) tick();
      s_axi_wvalid = 1'b1; s_axi_wdata = b[i].data;
      s_axi_wstrb = b[i].strb; s_axi_wlast = b[i].last;
      ok = 1'b0;
      for (int t = 0; t < TMO && !ok; t++) begin
        @(negedge aclk);
        if (s_axi_wready) ok = 1'b1;
      end
      if (!ok) begin
        s_axi_wvalid = 1'b0;
        tmo("w_beat");
        return;
      end
      tick();
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    end
  endtask

  task automatic wait_b();
    bit done = 1'b0;
    for (int t = 0; t < TMO && !done; t++) begin
      s_axi_bready = bp ? 1'($urandom) : 1'b1;
      @(negedge aclk);
      if (s_axi_bvalid && s_axi_bready) done = 1'b1;
      tick();
    end
    s_axi_bready = 1'b0;
    if (!done) tmo("b_handshake");
  endtask

  task automatic recv_r();
    bit done = 1'b0;
    for (int t = 0; t < TMO && !done; t++) begin
      s_axi_rready = bp ? 1'($urandom) : 1'b1;
      @(negedge aclk);
      if (s_axi_rvalid && s_axi_rready && s_axi_rlast) done = 1'b1;
      tick();
    end
    s_axi_rready = 1'b0;
    if (!done) tmo("r_last");
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] a,
                          input logic [7:0] len, input logic [2:0] sz,
                          input bit incr);
    fork
      send_aw(id, a, len, sz);
      send_w(int'(len) + 1, incr, 1000);
    join
    wait_b();
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] a,
                         input logic [7:0] len, input logic [2:0] sz);
    send_ar(id, a, len, sz);
    recv_r();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 resetn = 1'b0;
    repeat (3) tick();
    check("reset_ctrl", {m_avalid, m_wvalid, m_rready, s_axi_awready,
          s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid}, 0);
    check("reset_fields", {m_arnw, m_aaddr, m_abytes}, 0);
    resetn = 1'b1;
    tick();
    mon_en = 1'b1;

    fork
      do_write(8'h11, 32'h300, 8'd1, 3'd2, 1'b0);
      do_read(8'h22, 32'h400, 8'd1, 3'd2);
    join
    check("grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("first_grant_rnw", grant_log[0], 0);
      check("second_grant_rnw", grant_log[1], 1);
    end

    do_write(8'h5A, 32'h100, 8'd3, 3'd2, 1'b1);
    check("wr_aaddr", seen_addr, 32'h100);
    check("wr_abytes", seen_bytes, 16);
    check("wr_arnw", seen_rnw, 1);
    check("wr_beats", seen_wbeats, 4);

    do_read(8'hA5, 32'h200, 8'd7, 3'd2);
    check("rd_abytes", seen_bytes, 32);
    check("rd_arnw", seen_rnw, 0);
    check("rd_beats", seen_rbeats, 8);

    do_read(8'h01, 32'h500, 8'd0, 3'd2);
    check("len0_beats", seen_rbeats, 1);
    check("len0_abytes", seen_bytes, 4);

    do_read(8'h02, 32'h1000, 8'd255, 3'd2);
    check("len255_abytes", seen_bytes, 1024);
    check("len255_beats", seen_rbeats, 256);

    bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      automatic logic [7:0] l1 = 8'($urandom % 16);
      automatic logic [7:0] l2 = 8'($urandom % 16);
      automatic logic [2:0] s1 = 3'($urandom % 3);
      automatic logic [AW-1:0] a1 = {$urandom} & 32'hFFFF_FFF0;
      automatic int kind = $urandom % 4;
      if (kind == 0) begin
        fork
          do_write(8'($urandom), a1, l1, s1, 1'b0);
          do_read(8'($urandom), a1 ^ 32'h40, l2, s1);
        join
      end else if (kind == 1) begin
        do_read(8'($urandom), a1, l1, s1);
      end else begin
        do_write(8'($urandom), a1, l1, s1, 1'b0);
      end
    end
    bp = 1'b0;
    tick();
    check("w_queue_drained", exp_w.size(), 0);

    fork
      send_aw(8'h77, 32'h800, 8'd3, 3'd2);
      send_w(4, 1'b1, 2);
    join
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h3; s_axi_wstrb = 4'hF;
    #1;
    check("prereset_wvalid", {m_wvalid, s_axi_wready}, 2'b11);
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    check("abort_ctrl", {m_avalid, m_wvalid, m_rready, s_axi_awready,
          s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid}, 0);
    check("abort_fields", {m_arnw, m_aaddr, m_abytes}, 0);
    s_axi_wvalid = 1'b0;
    exp_w.delete();
    mdl_stage = 0; mdl_lw = 1'b1; r_hs = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    mon_en = 1'b1;
    do_read(8'h33, 32'h600, 8'd3, 3'd2);
    check("post_reset_beats", seen_rbeats, 4);
    check("post_reset_abytes", seen_bytes, 16);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slave_to_axis_port.md
# axi_slave_to_axis_port

Minimal-latency AXI4 slave that accepts memory-mapped read and write bursts and turns them into one port of the team's AXIS-style memory client interface. That interface is an address channel carrying rnw/addr/bytes, plus a write stream and a read stream. It sits on the client side of the AXIS-to-AXI crossbar, so an AXI master such as a soft CPU or a DMA can share memory through a crossbar port. Only one transaction is outstanding at a time. Reads and writes alternate when both are pending.

## Interface
- DATA_WIDTH, 32: AXI and stream data width.
- ADDR_WIDTH, 32: address width; also the width of the byte count.
- STRB_WIDTH, 4: DATA_WIDTH/8.
- ID_WIDTH, 8: AXI ID width.
- aclk  in  1  single clock; all logic is rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- s_axi_aw{id,addr,len,size,burst,valid}  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1; s_axi_awready out 1.
- s_axi_w{data,strb,last,valid}  in  DATA_WIDTH/STRB_WIDTH/1/1; s_axi_wready out 1.
- s_axi_b{id,resp,valid}  out  ID_WIDTH/2/1; s_axi_bready in 1.
- s_axi_ar{id,addr,len,size,burst,valid}  in  as AW; s_axi_arready out 1.
- s_axi_r{id,data,resp,last,valid}  out  ID_WIDTH/DATA_WIDTH/2/1/1; s_axi_rready in 1.
- m_avalid out 1, m_arnw out 1 (0 read, 1 write), m_aaddr out ADDR_WIDTH, m_abytes out ADDR_WIDTH, m_aready in 1: address channel.
- m_wvalid out 1, m_wready in 1, m_wlast out 1, m_wdata out DATA_WIDTH, m_wstrb out STRB_WIDTH: write stream.
- m_rvalid in 1, m_rready out 1, m_rlast in 1, m_rdata in DATA_WIDTH, m_rstrb in STRB_WIDTH: read stream. m_rlast and m_rstrb are ignored.

## Operation
- FSM states:
  - IDLE → ADDR on an AW or AR handshake.
  - ADDR → WDATA (write) or RDATA (read) on m_avalid&&m_aready.
  - WDATA → WRESP on the W beat with s_axi_wlast.
  - WRESP → IDLE on bvalid&&bready.
  - RDATA → IDLE on the R handshake with rlast.
- IDLE arbitration:
  - With only one of AWVALID/ARVALID set, grant it.
  - With both set, grant the type not served last. The `lastWasWrite` flag resets to 1, so the first contended grant goes to the read.
  - s_axi_awready = IDLE && grantWrite; s_axi_arready = IDLE && grantRead. Both are combinational and never high together.
- On grant, latch id, addr, len and arnw.
  - m_abytes = (len+1) << size, computed in ADDR_WIDTH bits.
  - burst is ignored and the request is treated as INCR.
- ADDR: m_avalid=1 and held stable until m_aready.
- WDATA:
  - m_wvalid = s_axi_wvalid and s_axi_wready = m_wready.
  - wdata, wstrb and wlast pass through unchanged.
  - The transaction ends on AXI wlast. The beat count is not checked.
- WRESP: bvalid=1, bid = latched id, bresp = 2'b00 (OKAY).
- RDATA:
  - s_axi_rvalid = m_rvalid and m_rready = s_axi_rready.
  - rdata passes through; rid = latched id; rresp = OKAY.
  - A beat counter, cleared on entry, drives rlast = (count == len).
- Outside WDATA, s_axi_wready and m_wvalid are 0, so W beats that arrive early wait at AXI.
- Outside RDATA, m_rready and s_axi_rvalid are 0.

## Timing
- Reset values: state IDLE, lastWasWrite=1; m_avalid, bvalid, rvalid, all readys and m_wvalid = 0; latched fields 0.
- Address latency: m_avalid rises the cycle after the AW/AR handshake.
- Data paths are combinational pass-through with zero added latency, one beat per cycle at full throughput.
- bvalid rises the cycle after the wlast handshake.
- After the B handshake (write) or the rlast handshake (read), IDLE is re-entered the next cycle, and a new grant can occur in that IDLE cycle.
- len=0: a single beat; rlast is high on the first beat.
- len=255: 256 beats; counter is 8 bits and rlast fires at count==255; no wrap before the end.
- AW and AR asserted in the same cycle: only the arbitration winner is acked. The other stays pending and is served after the current transaction.
- resetn asserted mid-burst: immediate abort to the reset values, with no B or R response. The downstream port is expected to be reset by the same signal.

## Structure
- Shared package `axis_axi_pkg`:
  - state enum (IDLE, ADDR, WDATA, WRESP, RDATA);
  - AXI_RESP_OKAY = 2'b00;
  - AXI_BURST_INCR = 2'b01;
  - the bytes-from-len/size function, reusable by the crossbar side.
- No sub-module: arbitration and the FSM stay inline; the block is about 200 lines.

## Test plan
- Single write: awaddr=0x100, awlen=3, awsize=2, wdata 1..4 with stream ready.
  - m_aaddr=0x100, m_abytes=16, m_arnw=1.
  - 4 beats out, m_wlast on beat 4.
  - bvalid next cycle with bid = awid, bresp=0.
- Single read: araddr=0x200, arlen=7, size=2, stream supplies 8 beats.
  - m_abytes=32, m_arnw=0.
  - s_axi_rlast only on beat 8; rid = arid.
- Simultaneous AW+AR from reset: read granted first, then write; arready and awready never high in the same cycle.
- Backpressure: toggle m_aready, m_wready and s_axi_rready randomly.
  - m_avalid is held stable until m_aready.
  - No beats are dropped or duplicated.
  - Write data appears on m_w* only after the address handshake.
- Boundaries: arlen=0 gives a single beat with rlast; arlen=255, size=2 gives m_abytes=1024 and 256 beats.
- Reset mid-write after 2 of 4 beats: all outputs return to 0 the same cycle. After release, a fresh read completes normally.
